// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Build option: define UART_TX_FIFO_EN for a 4-entry transmit FIFO (default: 1-entry holding register).
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;

    localparam logic [2:0] MODE_WORD = 3'b010;

`ifdef UART_TX_FIFO_EN
    localparam int TX_QUEUE_DEPTH = 4;
`else
    localparam int TX_QUEUE_DEPTH = 1;
`endif

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU memory-port handshake between a load/store stage (master) and the UART (slave).
interface mmio_uart_tx_if;
    logic        start;
    logic [31:0] address;
    logic [2:0]  mode;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        active;
    logic        illegal_address;

    modport master (
        output start, address, mode, write_enable, write_data,
        input  read_data, done, active, illegal_address
    );

    modport slave (
        input  start, address, mode, write_enable, write_data,
        output read_data, done, active, illegal_address
    );
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte queue between the MMIO store path and the serializer; first-word fall-through output.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: storage is not reset; count/pointers gate every read, so contents never matter until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store queues a byte, STATUS load reports {full, busy}.
// Build option: UART_TX_FIFO_EN selects the 4-entry queue (see mmio_uart_tx_pkg).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);

    localparam int          CW       = $clog2(TX_QUEUE_DEPTH + 1);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic          q_push;
    logic          q_pop;
    logic [7:0]    q_din;
    logic [7:0]    q_dout;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    tx_state_e     state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          active_q;
    logic          done_q;
    logic          illegal_q;
    logic [31:0]   read_data_q;
    logic          stalled;
    logic [7:0]    pend_byte;

    logic          addr_txdata;
    logic          addr_status;
    logic          accept;
    logic          can_push;
    logic          busy;
    logic [31:0]   status_word;
    logic          unused_bits;

    uart_tx_fifo #(
        .DEPTH (TX_QUEUE_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign addr_txdata = (bus.address == BASE_ADDR + TXDATA_OFS);
    assign addr_status = (bus.address == BASE_ADDR + STATUS_OFS);
    assign accept      = bus.start && !active_q;
    assign busy        = (state != IDLE) || (q_count != '0);

    // The serializer takes the head when idle, or at the very end of a stop bit for gapless frames.
    assign q_pop    = !q_empty && ((state == IDLE) || (state == STOP && bit_cnt == '0));
    assign can_push = !q_full || q_pop;
    assign q_push   = can_push && (stalled || (accept && addr_txdata && bus.write_enable));
    assign q_din    = stalled ? pend_byte : bus.write_data[7:0];

    // Access size and upper store bits carry no meaning for this byte-wide device.
    assign unused_bits = ^{bus.mode == MODE_WORD, bus.write_data[31:8]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        status_word                  = '0;
        status_word[STATUS_BUSY_BIT] = busy;
        status_word[STATUS_FULL_BIT] = q_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            read_data_q <= '0;
            stalled     <= 1'b0;
            pend_byte   <= '0;
        end else begin
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            read_data_q <= '0;
            if (stalled) begin
                if (can_push) begin
                    stalled <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (active_q) begin
                active_q <= 1'b0;
            end else if (accept) begin
                active_q <= 1'b1;
                if (addr_txdata) begin
                    if (bus.write_enable && !can_push) begin
                        stalled   <= 1'b1;
                        pend_byte <= bus.write_data[7:0];
                    end else begin
                        done_q <= 1'b1;
                    end
                end else if (addr_status) begin
                    done_q <= 1'b1;
                    if (!bus.write_enable) read_data_q <= status_word;
                end else begin
                    done_q    <= 1'b1;
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        state   <= START;
                        shreg   <= q_dout;
                        bit_cnt <= BIT_LAST;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_cnt == '0) begin
                        state   <= DATA;
                        bit_cnt <= BIT_LAST;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_LAST;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt == '0) begin
                        if (!q_empty) begin
                            state   <= START;
                            shreg   <= q_dout;
                            bit_cnt <= BIT_LAST;
                            tx      <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.active          = active_q;
    assign bus.done            = done_q;
    assign bus.illegal_address = illegal_q;
    assign bus.read_data       = read_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a timeline model of queue and serial frames.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte queue plus the cycle span of the frame currently on the line.
    int          cyc         = 0;
    logic [7:0]  mq [$];
    int          frame_start = -1000;
    int          frame_end   = -1;
    logic [7:0]  frame_byte  = 8'h00;
    bit          m_active    = 0;
    bit          m_done      = 0;
    bit          m_ill       = 0;
    bit          m_stalled   = 0;
    logic [7:0]  m_pend      = 8'h00;
    logic [31:0] m_rd        = '0;

    function automatic logic exp_tx(input int t);
        int b;
        if (t < frame_start || t >= frame_start + FRAME) return 1'b1;
        b = (t - frame_start) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return frame_byte[b-1];
    endfunction

    always @(posedge clk) begin
        bit pop, full, busy, can_push, do_push, nd, nill;
        logic [7:0]  pb;
        logic [31:0] nrd;
        if (rst) begin
            mq.delete();
            frame_start = -1000;
            frame_end   = -1;
            m_active    = 0;
            m_done      = 0;
            m_ill       = 0;
            m_stalled   = 0;
            m_rd        = '0;
        end else begin
            full     = (mq.size() == DEPTH);
            busy     = (cyc <= frame_end) || (mq.size() > 0);
            pop      = (mq.size() > 0) && (cyc >= frame_end);
            can_push = !full || pop;
            nd = 0; nill = 0; nrd = '0; do_push = 0; pb = 8'h00;
            if (m_stalled) begin
                if (can_push) begin
                    do_push = 1; pb = m_pend; m_stalled = 0; nd = 1;
                end
            end else if (m_active) begin
                m_active = 0;
            end else if (bus.start) begin
                m_active = 1;
                if (bus.address == BASE) begin
                    if (bus.write_enable && !can_push) begin
                        m_stalled = 1; m_pend = bus.write_data[7:0];
                    end else begin
                        nd = 1;
                        if (bus.write_enable) begin
                            do_push = 1; pb = bus.write_data[7:0];
                        end
                    end
                end else if (bus.address == BASE + 32'd4) begin
                    nd = 1;
                    if (!bus.write_enable) nrd = {30'b0, full, busy};
                end else begin
                    nd = 1; nill = 1;
                end
            end
            if (pop) begin
                frame_byte  = mq.pop_front();
                frame_start = cyc + 1;
                frame_end   = cyc + FRAME;
            end
            if (do_push) mq.push_back(pb);
            m_done = nd;
            m_ill  = nill;
            m_rd   = nrd;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("tx", {31'b0, tx}, {31'b0, exp_tx(cyc)});
            check("done", {31'b0, bus.done}, {31'b0, m_done});
            check("active", {31'b0, bus.active}, {31'b0, m_active});
            check("illegal_address", {31'b0, bus.illegal_address}, {31'b0, m_ill});
            if (m_done) check("read_data", bus.read_data, m_rd);
        end
    end

    task automatic pulse(input logic [31:0] a, input bit w, input logic [31:0] d);
        bus.start        = 1'b1;
        bus.address      = a;
        bus.write_enable = w;
        bus.write_data   = d;
        bus.mode         = 3'($urandom_range(0, 7));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input bit w, input logic [31:0] d);
        int budget = 0;
        while (m_active && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 5000) check("req_wait_timeout", 32'd1, 32'd0);
        pulse(a, w, d);
    endtask

    task automatic drain();
        int budget = 0;
        while ((m_active || mq.size() > 0 || cyc <= frame_end + 1) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20000) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          budget;
        bus.start        = 1'b0;
        bus.address      = '0;
        bus.mode         = 3'b010;
        bus.write_enable = 1'b0;
        bus.write_data   = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_active", {31'b0, bus.active}, 32'd0);
        check("reset_illegal", {31'b0, bus.illegal_address}, 32'd0);
        check("reset_read_data", bus.read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame of 0x55, then status and illegal accesses.
        req(BASE, 1'b1, 32'hFFFF_FF55);
        req(BASE + 32'd4, 1'b0, '0);
        drain();
        req(BASE + 32'd8, 1'b0, '0);
        req(BASE + 32'd2, 1'b0, '0);
        req(BASE + 32'd8, 1'b1, 32'h0000_00AA);
        req(BASE + 32'd4, 1'b1, 32'h0000_00CC);
        req(BASE, 1'b0, '0);
        req(BASE + 32'd4, 1'b0, '0);
        drain();

        // Back-to-back burst past the queue depth, with status polls while draining.
        for (int i = 1; i <= DEPTH + 2; i++) req(BASE, 1'b1, 32'(i));
        req(BASE + 32'd4, 1'b0, '0);
        req(BASE + 32'd4, 1'b0, '0);
        drain();
        req(BASE + 32'd4, 1'b0, '0);

        // A start while the previous access is still active must be ignored.
        req(BASE, 1'b1, 32'h0000_00C3);
        pulse(BASE, 1'b1, 32'h0000_003C);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = BASE;
                4, 5:       a = BASE + 32'd4;
                6:          a = BASE + 32'(4 * $urandom_range(2, 8));
                default:    a = BASE + 32'($urandom_range(1, 3));
            endcase
            req(a, ($urandom_range(0, 3) != 0), $urandom);
            if ($urandom_range(0, 9) == 0) repeat (60) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Reset in the middle of a frame with more bytes queued or stalled.
        req(BASE, 1'b1, 32'h0000_00A5);
        req(BASE, 1'b1, 32'h0000_005A);
        req(BASE, 1'b1, 32'h0000_0081);
        budget = 0;
        while (!(cyc >= frame_start + 3 * CPB && cyc < frame_start + 8 * CPB) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) check("mid_frame_timeout", 32'd1, 32'd0);
        rst = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'd1);
        check("async_reset_active", {31'b0, bus.active}, 32'd0);
        check("async_reset_done", {31'b0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req(BASE + 32'd4, 1'b0, '0);
        repeat (3 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
